scan_mux: RTL and testbench

//  Parametrised N-channel, WIDTH-bit registered multiplexer. Generalised successor of the 8:1 bit mux.
//  Two select modes:
//   - MANUAL: select comes from a port.
//   - SCAN: channels are stepped automatically with a programmable dwell time.

---
 rtl/scan_mux.sv | 111 +++++++++++
 tb/tb_scan_mux.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// N-channel registered mux with manual select or automatic scan at a programmable dwell.
// Latency 1 cycle from d/sel to y; no backpressure, en=0 freezes data outputs and drops y_valid.
module scan_mux #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 1,
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic                  en,
  output logic [WIDTH-1:0]      y,
  output logic                  y_valid,
  output logic [SEL_W-1:0]      ch_out,
  output logic                  sel_err,
  output logic                  scan_wrap
);

  localparam int NSLOT = 1 << SEL_W;
  localparam int DW_W  = $clog2(DWELL) + 1;

  localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(N_CH - 1);
  localparam logic [DW_W-1:0]  LAST_DW   = DW_W'(DWELL - 1);
  localparam logic [SEL_W:0]   N_CH_EXT  = (SEL_W + 1)'(N_CH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] scan_ch;
  logic [DW_W-1:0]  dwell_cnt;

  // Every select code maps to a slot; codes past N_CH read as zero.
  logic [WIDTH-1:0] chan [NSLOT];

  for (genvar k = 0; k < NSLOT; k++) begin : g_chan
    if (k < N_CH) begin : g_real
      assign chan[k] = d[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chan[k] = '0;
    end
  end

  logic             sel_bad;
  logic             scan_entry;
  logic [SEL_W-1:0] cur_ch;
  logic [DW_W-1:0]  cur_dw;
  logic [SEL_W-1:0] nxt_ch;

  assign sel_bad = ({1'b0, sel} >= N_CH_EXT);

  // Entering SCAN uses channel 0 on the same edge, so no stale channel is emitted.
  always_comb begin
    scan_entry = (state != SCAN);
    cur_ch     = scan_entry ? '0 : scan_ch;
    cur_dw     = scan_entry ? '0 : dwell_cnt;
    nxt_ch     = (cur_ch == LAST_CH) ? '0 : cur_ch + SEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scan_ch   <= '0;
      dwell_cnt <= '0;
      y         <= '0;
      y_valid   <= 1'b0;
      ch_out    <= '0;
      sel_err   <= 1'b0;
      scan_wrap <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      y_valid   <= 1'b0;
      scan_wrap <= 1'b0;
    end else if (!mode) begin
      state     <= MANUAL;
      ch_out    <= sel;
      scan_wrap <= 1'b0;
      if (sel_bad) begin
        y       <= '0;
        sel_err <= 1'b1;
        y_valid <= 1'b0;
      end else begin
        y       <= chan[sel];
        sel_err <= 1'b0;
        y_valid <= 1'b1;
      end
    end else begin
      state     <= SCAN;
      y         <= chan[cur_ch];
      ch_out    <= cur_ch;
      y_valid   <= 1'b1;
      sel_err   <= 1'b0;
      // Channel 0 at dwell 0 while already scanning can only follow a wrap.
      scan_wrap <= !scan_entry && (cur_ch == '0) && (cur_dw == '0);
      if (cur_dw == LAST_DW) begin
        dwell_cnt <= '0;
        scan_ch   <= nxt_ch;
      end else begin
        dwell_cnt <= cur_dw + DW_W'(1);
        scan_ch   <= cur_ch;
      end
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: reset, manual sweep, select error, scan wrap, enable/mode, WIDTH>1.
module tb_scan_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode;
  logic [2:0] sel;
  logic [7:0]  d_a;
  logic [5:0]  d_b;
  logic [63:0] d_c;

  logic       y_a, yv_a, err_a, wrap_a;
  logic [2:0] ch_a;
  logic       y_b, yv_b, err_b, wrap_b;
  logic [2:0] ch_b;
  logic [7:0] y_c;
  logic       yv_c, err_c, wrap_c;
  logic [2:0] ch_c;

  int checks = 0;
  int errors = 0;

  scan_mux #(.N_CH(8), .WIDTH(1), .SEL_W(3), .DWELL(4)) u_a (
    .clk(clk), .rst(rst), .d(d_a), .sel(sel), .mode(mode), .en(en),
    .y(y_a), .y_valid(yv_a), .ch_out(ch_a), .sel_err(err_a), .scan_wrap(wrap_a));

  scan_mux #(.N_CH(6), .WIDTH(1), .SEL_W(3), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .d(d_b), .sel(sel), .mode(mode), .en(en),
    .y(y_b), .y_valid(yv_b), .ch_out(ch_b), .sel_err(err_b), .scan_wrap(wrap_b));

  scan_mux #(.N_CH(8), .WIDTH(8), .SEL_W(3), .DWELL(4)) u_c (
    .clk(clk), .rst(rst), .d(d_c), .sel(sel), .mode(mode), .en(en),
    .y(y_c), .y_valid(yv_c), .ch_out(ch_c), .sel_err(err_c), .scan_wrap(wrap_c));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, ".y"}, 64'(y_a), 64'd0);
    chk({tag, ".y_valid"}, 64'(yv_a), 64'd0);
    chk({tag, ".ch_out"}, 64'(ch_a), 64'd0);
    chk({tag, ".sel_err"}, 64'(err_a), 64'd0);
    chk({tag, ".scan_wrap"}, 64'(wrap_a), 64'd0);
  endtask

  initial begin
    int exp_ch;
    logic [7:0] last_y;

    // T1: reset dominates random inputs
    rst = 1'b1;
    en = 1'($urandom_range(1)); mode = 1'($urandom_range(1)); sel = 3'($urandom_range(7));
    d_a = 8'($urandom); d_b = 6'($urandom); d_c = {$urandom, $urandom};
    tick();
    chk_zero_a("t1_rst_a");
    chk("t1_rst_c.y", 64'(y_c), 64'd0);
    chk("t1_rst_b.valid", 64'(yv_b), 64'd0);
    en = 1'b1; mode = 1'($urandom_range(1)); sel = 3'($urandom_range(7)); d_a = 8'($urandom);
    tick();
    chk_zero_a("t1_hold_a");

    // T2: manual sweep over all channels
    rst = 1'b0; en = 1'b1; mode = 1'b0;
    d_a = 8'b1010_1010;
    d_b = 6'b11_0101;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      tick();
      chk("t2_y", 64'(y_a), 64'(i % 2));
      chk("t2_ch", 64'(ch_a), 64'(i));
      chk("t2_valid", 64'(yv_a), 64'd1);
      chk("t2_err", 64'(err_a), 64'd0);
    end

    // T4: out-of-range select on 6-channel instance
    sel = 3'd6; tick();
    chk("t4_sel6_y", 64'(y_b), 64'd0);
    chk("t4_sel6_err", 64'(err_b), 64'd1);
    chk("t4_sel6_valid", 64'(yv_b), 64'd0);
    chk("t4_sel6_ch", 64'(ch_b), 64'd6);
    sel = 3'd7; tick();
    chk("t4_sel7_err", 64'(err_b), 64'd1);
    chk("t4_sel7_valid", 64'(yv_b), 64'd0);
    sel = 3'd2; tick();
    chk("t4_sel2_err", 64'(err_b), 64'd0);
    chk("t4_sel2_y", 64'(y_b), 64'd1);
    chk("t4_sel2_valid", 64'(yv_b), 64'd1);
    sel = 3'd7; tick();
    chk("t4_sel7b_err", 64'(err_b), 64'd1);

    // T3: scan with DWELL=4 on u_a and DWELL=1 on u_b; sel left at an invalid code
    mode = 1'b1;
    d_a = 8'b1100_1010;
    for (int c = 0; c < 64; c++) begin
      tick();
      exp_ch = (c / 4) % 8;
      chk("t3_ch", 64'(ch_a), 64'(exp_ch));
      chk("t3_y", 64'(y_a), 64'(d_a[exp_ch]));
      chk("t3_wrap", 64'(wrap_a), 64'((c > 0) && (c % 32 == 0)));
      chk("t3_valid", 64'(yv_a), 64'd1);
      chk("t3b_ch", 64'(ch_b), 64'(c % 6));
      chk("t3b_y", 64'(y_b), 64'(d_b[c % 6]));
      chk("t3b_wrap", 64'(wrap_b), 64'((c > 0) && (c % 6 == 0)));
      chk("t3b_err", 64'(err_b), 64'd0);
    end

    // T5: enable drop holds, re-enable restarts scan, then switch to manual
    en = 1'b0; tick();
    en = 1'b1;
    for (int c = 0; c < 14; c++) tick();
    chk("t5_at3_ch", 64'(ch_a), 64'd3);
    chk("t5_at3_y", 64'(y_a), 64'd1);
    en = 1'b0; d_a = 8'h00;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_hold_ch", 64'(ch_a), 64'd3);
      chk("t5_hold_y", 64'(y_a), 64'd1);
      chk("t5_hold_valid", 64'(yv_a), 64'd0);
      chk("t5_hold_wrap", 64'(wrap_a), 64'd0);
    end
    en = 1'b1; d_a = 8'b1100_1010;
    tick();
    chk("t5_restart_ch", 64'(ch_a), 64'd0);
    chk("t5_restart_y", 64'(y_a), 64'd0);
    chk("t5_restart_valid", 64'(yv_a), 64'd1);
    chk("t5_restart_wrap", 64'(wrap_a), 64'd0);
    tick(); tick(); tick();
    chk("t5_dwell_ch0", 64'(ch_a), 64'd0);
    tick();
    chk("t5_dwell_ch1", 64'(ch_a), 64'd1);
    mode = 1'b0; sel = 3'd5; d_a = 8'b1110_1010;
    tick();
    chk("t5_manual_ch", 64'(ch_a), 64'd5);
    chk("t5_manual_y", 64'(y_a), 64'd1);
    chk("t5_manual_valid", 64'(yv_a), 64'd1);

    // T6: WIDTH=8, mid-scan reset
    for (int k = 0; k < 8; k++) d_c[k*8 +: 8] = 8'(8'h10 + k);
    rst = 1'b1; tick();
    rst = 1'b0; mode = 1'b1; en = 1'b1;
    for (int c = 0; c < 21; c++) tick();
    chk("t6_at5_ch", 64'(ch_c), 64'd5);
    chk("t6_at5_y", 64'(y_c), 64'h15);
    d_c[5*8 +: 8] = 8'hA5;
    tick();
    last_y = y_c;
    chk("t6_resample_y", 64'(last_y), 64'hA5);
    rst = 1'b1; tick();
    chk("t6_rst_y", 64'(y_c), 64'd0);
    chk("t6_rst_ch", 64'(ch_c), 64'd0);
    chk("t6_rst_valid", 64'(yv_c), 64'd0);
    chk("t6_rst_wrap", 64'(wrap_c), 64'd0);
    chk("t6_rst_err", 64'(err_c), 64'd0);
    rst = 1'b0; tick();
    chk("t6_resume_ch", 64'(ch_c), 64'd0);
    chk("t6_resume_y", 64'(y_c), 64'h10);
    chk("t6_resume_valid", 64'(yv_c), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
